// File: rtl/hd_pkg.sv
// Shared types for the adder-tree front end: default sizes, the packed lane
// vector and the packer state encoding.
package hd_pkg;

    localparam int NUM_LANES_DEFAULT   = 16;
    localparam int INPUT_WIDTH_DEFAULT = 8;

    typedef logic [NUM_LANES_DEFAULT-1:0][INPUT_WIDTH_DEFAULT-1:0] lane_vec_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } packer_state_t;

endpackage

// File: rtl/pipelined_lane_packer.sv
// Packs one INPUT_WIDTH element per cycle into a NUM_LANES-wide vector for the
// adder tree. A fill buffer plus an output register give full-rate streaming:
// the next batch fills while the previous vector waits for out_ready.
// Optional macro PACKER_FLUSH_EN: in_last completes a short batch early, with
// the unused upper lanes left at zero and out_count = number of filled lanes.
module pipelined_lane_packer
    import hd_pkg::*;
#(
    parameter int INPUT_WIDTH = INPUT_WIDTH_DEFAULT,
    parameter int NUM_LANES   = NUM_LANES_DEFAULT
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [INPUT_WIDTH-1:0]                 in_data,
    input  logic                                   in_last,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [NUM_LANES-1:0][INPUT_WIDTH-1:0]  out_lanes,
    output logic [$clog2(NUM_LANES):0]             out_count
);

    localparam int CW = $clog2(NUM_LANES);
    localparam int OW = CW + 1;

    typedef logic [NUM_LANES-1:0][INPUT_WIDTH-1:0] vec_t;

    packer_state_t  state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    vec_t           fill_q, fill_d;
    vec_t           out_lanes_q, out_lanes_d;
    logic [OW-1:0]  out_count_q, out_count_d;
    logic           out_valid_q, out_valid_d;

    logic           accept;
    logic           out_free;
    logic           last_hit;
    logic           complete;
    vec_t           fill_w;

`ifdef PACKER_FLUSH_EN
    assign last_hit = in_last;
`else
    // in_last has no effect in this build; batches close only when full.
    assign last_hit = 1'b0 & in_last;
`endif

    // Ready depends only on state (and is held low during reset).
    assign in_ready = reset_n && (state_q == FILL);
    assign accept   = in_valid && in_ready;
    assign out_free = !out_valid_q || out_ready;
    assign complete = accept && ((cnt_q == CW'(NUM_LANES - 1)) || last_hit);

    assign out_valid = out_valid_q;
    assign out_lanes = out_lanes_q;
    assign out_count = out_count_q;

    // Next-state: lane write, batch completion, and fill-to-output transfer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_d      = fill_q;
        out_lanes_d = out_lanes_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;

        fill_w = fill_q;
        if (accept) begin
            fill_w[cnt_q] = in_data;
        end

        // Drained this edge; a load below may re-assert it with no bubble.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            FILL: begin
                if (accept) begin
                    fill_d = fill_w;
                    cnt_d  = cnt_q + CW'(1);
                    if (complete) begin
                        if (out_free) begin
                            out_lanes_d = fill_w;
                            out_count_d = OW'(cnt_q) + OW'(1);
                            out_valid_d = 1'b1;
                            cnt_d       = '0;
                            fill_d      = '0;
                        end else begin
                            // Keep cnt at the last lane so the count is known at transfer.
                            cnt_d   = cnt_q;
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (out_free) begin
                    out_lanes_d = fill_q;
                    out_count_d = OW'(cnt_q) + OW'(1);
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    fill_d      = '0;
                    state_d     = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // All packer state; synchronous reset drops any partial or held batch.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            fill_q      <= '0;
            out_lanes_q <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_q      <= fill_d;
            out_lanes_q <= out_lanes_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_pipelined_lane_packer.sv
// Directed + random bench for pipelined_lane_packer. A queue-based model tracks
// completed-but-unconsumed vectors and is compared with the DUT every cycle.
module tb_pipelined_lane_packer;
    import hd_pkg::*;

    localparam int NL = NUM_LANES_DEFAULT;
    localparam int IW = INPUT_WIDTH_DEFAULT;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [IW-1:0]   in_data = '0;
    logic            in_last = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    lane_vec_t       out_lanes;
    logic [$clog2(NL):0] out_count;

    int n_cmp = 0;
    int n_err = 0;
    int n_vec = 0;

    pipelined_lane_packer #(.INPUT_WIDTH(IW), .NUM_LANES(NL)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lanes(out_lanes), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        lane_vec_t lanes;
        int        cnt;
    } exp_t;

    exp_t      pend[$];     // completed vectors not yet taken by downstream (at most 2)
    lane_vec_t part;
    int        pcnt = 0;
    bit        started = 1'b0;

    always @(posedge clk) begin
        bit hs, acc, fin;
        exp_t e;
        started = 1'b1;
        if (!reset_n) begin
            pend.delete();
            part = '0;
            pcnt = 0;
        end else begin
            hs  = (pend.size() > 0) && out_ready;
            acc = in_valid && (pend.size() < 2);
            if (hs) begin
                void'(pend.pop_front());
                n_vec++;
            end
            if (acc) begin
                part[pcnt] = in_data;
                pcnt++;
                fin = (pcnt == NL);
`ifdef PACKER_FLUSH_EN
                if (in_last) fin = 1'b1;
`endif
                if (fin) begin
                    e.lanes = part;
                    e.cnt   = pcnt;
                    pend.push_back(e);
                    part = '0;
                    pcnt = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("in_ready", in_ready, reset_n && (pend.size() < 2));
            check("out_valid", out_valid, pend.size() > 0);
            if (pend.size() > 0) begin
                check("out_lanes", out_lanes, pend[0].lanes);
                check("out_count", out_count, pend[0].cnt);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [IW-1:0] d, input logic l);
        bit r;
        bit done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            done = r;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got no accept expected accept within 100 cycles");
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset
        reset_n = 1'b0;
        idle(3);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_lanes", out_lanes, 0);
        check("reset_out_count", out_count, 0);
        check("reset_in_ready", in_ready, 1'b0);
        reset_n = 1'b1;

        // 0..15 with out_ready=1: vector in the cycle after the last accept, then gone.
        out_ready = 1'b1;
        for (int i = 0; i < NL; i++) send(IW'(i), 1'b0);
        @(negedge clk);
        check("t1_valid", out_valid, 1'b1);
        check("t1_lane0", out_lanes[0], 8'd0);
        check("t1_lane9", out_lanes[9], 8'd9);
        check("t1_lane15", out_lanes[15], 8'd15);
        check("t1_count", out_count, 16);
        @(negedge clk);
        check("t1_drop", out_valid, 1'b0);
        @(posedge clk);
        #1;

        // 32 elements of value 10 back to back.
        for (int i = 0; i < 2 * NL; i++) send(8'd10, 1'b0);
        idle(3);

        // Hold A, fill B, then release with a single out_ready pulse.
        out_ready = 1'b0;
        for (int i = 0; i < 2 * NL; i++) send(IW'(i), 1'b0);
        @(negedge clk);
        check("t3_in_ready_low", in_ready, 1'b0);
        check("t3_A_lane0", out_lanes[0], 8'd0);
        check("t3_A_lane15", out_lanes[15], 8'd15);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("t3_B_valid", out_valid, 1'b1);
        check("t3_B_lane0", out_lanes[0], 8'd16);
        check("t3_B_lane15", out_lanes[15], 8'd31);
        check("t3_in_ready_back", in_ready, 1'b1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(3);

        // Reset mid-batch after 7 elements, then a clean batch.
        for (int i = 0; i < 7; i++) send(IW'(50 + i), 1'b0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("t4_valid", out_valid, 1'b0);
        check("t4_lanes", out_lanes, 0);
        check("t4_count", out_count, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < NL; i++) send(IW'(100 + i), 1'b0);
        @(negedge clk);
        check("t4_lane0", out_lanes[0], 8'd100);
        check("t4_lane15", out_lanes[15], 8'd115);
        @(posedge clk);
        #1;

        // Early termination via in_last.
        send(8'd5, 1'b0);
        send(8'd6, 1'b0);
        send(8'd7, 1'b1);
        @(negedge clk);
`ifdef PACKER_FLUSH_EN
        check("t5_valid", out_valid, 1'b1);
        check("t5_lane1", out_lanes[1], 8'd6);
        check("t5_lane2", out_lanes[2], 8'd7);
        check("t5_lane3", out_lanes[3], 8'd0);
        check("t5_count", out_count, 3);
        @(posedge clk);
        #1;
`else
        check("t5_no_output", out_valid, 1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 13; i++) send(IW'(8 + i), 1'b0);
        @(negedge clk);
        check("t5_valid", out_valid, 1'b1);
        check("t5_lane2", out_lanes[2], 8'd7);
        check("t5_lane15", out_lanes[15], 8'd20);
        check("t5_count", out_count, 16);
        @(posedge clk);
        #1;
`endif
        idle(2);

        // Random valid/ready toggling, checked by the model every cycle.
        n_vec = 0;
        for (int c = 0; c < 1000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = IW'($urandom);
            in_last   = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        idle(5);
        check("rand_vectors_seen", n_vec > 20, 1'b1);
        check("rand_drained", out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipelined_lane_packer.md
Name: pipelined_lane_packer

Overview:
- Producer-side front end for the 16-lane pipelined adder tree. Accepts one INPUT_WIDTH element per cycle over a valid/ready stream and packs consecutive elements into a NUM_LANES-wide vector.
- Presents each completed vector to the tree input over a valid/ready handshake.
- Double-buffered (fill buffer plus output register), so a full-rate stream sustains one vector every NUM_LANES cycles with no bubbles.

Parameters:
- INPUT_WIDTH, 8, bit width of each element/lane.
- NUM_LANES, 16, lanes per packed vector. Power of two, at least 2.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  synchronous active-low reset, sampled on posedge clk.
- in_valid  input  1  in_data/in_last valid this cycle.
- in_ready  output  1  packer can accept an element this cycle.
- in_data  input  INPUT_WIDTH  element; the first element of a batch goes to lane 0.
- in_last  input  1  early batch termination; used only with PACKER_FLUSH_EN.
- out_valid  output  1  out_lanes holds a complete vector.
- out_ready  input  1  downstream tree accepts the vector.
- out_lanes  output  [NUM_LANES][INPUT_WIDTH]  packed vector, lane i = i-th accepted element.
- out_count  output  $clog2(NUM_LANES)+1  number of meaningful lanes in out_lanes (1..NUM_LANES).

Behaviour:
- Reset (reset_n low at posedge):
  - out_valid=0, out_lanes=0, out_count=0.
  - Lane counter=0, fill buffer=0, state FILL.
  - in_ready is forced 0 while reset_n is low.
  - Reset mid-batch discards the partial batch and any held vector.
- Acceptance: an element is accepted on a posedge where in_valid && in_ready. It is written to fill[cnt] and cnt increments.
- Batch completes when the accepted element has cnt==NUM_LANES-1.
- Output register is "free" when out_valid==0, or when out_valid && out_ready in the same cycle.
- State FILL:
  - in_ready=1.
  - On completion with output free: next cycle out_lanes<=fill (with the completing element in its lane), out_count<=NUM_LANES, out_valid<=1, cnt<=0, fill cleared. Stay in FILL.
  - On completion with output not free: fill is retained, go to HOLD.
- State HOLD:
  - in_ready=0.
  - When output becomes free: transfer fill to the output register (out_valid stays 1), clear fill, cnt<=0, return to FILL.
- Latency: last element accepted at edge N gives out_valid=1 and data visible after edge N (i.e. in cycle N+1).
- Simultaneous drain and load: if out_valid && out_ready and a completion or transfer occurs on the same edge, out_valid remains 1 with the new vector. There is no bubble cycle.
- Output stability: out_valid && !out_ready means out_lanes and out_count are held stable.
- in_ready is combinational from state only. It never depends on in_valid.
- Wrap-around: cnt wraps to 0 only via completion. No arithmetic is performed on data; lanes are copied bit-exact.
- Throughput: with in_valid=1 and out_ready=1 continuously, one vector is produced every NUM_LANES cycles.

Optional Feature:
- Macro: PACKER_FLUSH_EN.
- With the macro defined:
  - An accepted element with in_last=1 completes the batch immediately, regardless of cnt.
  - Lanes above cnt are zero, which is neutral for the adder tree.
  - out_count = cnt+1.
  - HOLD/transfer rules are identical to normal completion.
  - in_last on the NUM_LANES-th element is equivalent to normal completion.
- Without the macro:
  - in_last is ignored; batches complete only at NUM_LANES elements.
  - out_count is NUM_LANES whenever out_valid=1.

Decomposition:
- Shared package hd_pkg:
  - Constant NUM_LANES_DEFAULT=16.
  - Typedef lane_vec_t (logic [NUM_LANES-1:0][INPUT_WIDTH-1:0] at default widths).
  - State enum packer_state_t {FILL, HOLD}.
- No sub-module. The fill buffer, counter and output register are a single always_ff plus one combinational ready/next-state block.

Test Plan:
- Reset, then stream 0..15 with out_ready=1 -> in cycle 17 out_valid=1, out_lanes[i]=i, out_count=16; out_valid drops the next cycle.
- Stream 32 elements of value 10 with out_ready=1 -> two vectors with all lanes 10; in_ready never drops; vectors are 16 cycles apart.
- Complete vector A (0..15) with out_ready=0, then stream vector B (16..31) -> in_ready=0 after B's 16th element; A is held stable. Raise out_ready for one cycle -> B appears with out_valid still 1 and no gap; in_ready returns to 1.
- Assert reset_n=0 for one edge after 7 elements accepted -> outputs zero. The next 16 elements form a clean vector starting at lane 0.
- PACKER_FLUSH_EN: send 5,6,7 with in_last on 7 -> out_lanes = {5,6,7,0,...,0}, out_count=3. Without the macro, the same stimulus produces no output until 13 more elements arrive.
- Random in_valid/out_ready toggling for 1000 cycles -> a scoreboard confirms every accepted element appears once, in order, in the correct lane.
